pc_3gpp_alpha_engine: RTL and testbench
=======================================

Name: pc_3gpp_alpha_engine

Overview:
- Node-processing stage of the polar SC/SCL decoder.
- Walks a range of alpha-RAM words and reads pNUM LLRs per word: the a-half is ordat[0..pNUM/2-1], the b-half is ordat[pNUM/2..pNUM-1].
- Applies the min-sum f or g function lane-wise and writes pNUM/2 results back to the alpha RAM's write port, at the child layer's address and bank select.
- Both feeds and consumes the alpha RAM; it is the only agent driving the RAM's iraddr and write ports during a layer pass.

Parameters:
- pADDR_W, 8, alpha RAM address width.
- pDAT_W, 8, signed LLR width (two's complement).
- pNUM, 8, LLRs per read word (even); pNUM/2 lanes.
- pPIPE, 0, alpha RAM extra read pipe; must equal the RAM's pPIPE.

Ports:
- iclk, in, 1, clock.
- ireset, in, 1, synchronous active-high reset.
- iclkena, in, 1, clock enable; when low, all state holds.
- istart, in, 1, start pulse; sampled only in IDLE.
- imode, in, 1, 0 = f function, 1 = g function; latched at start.
- irbase, in, pADDR_W, first read address; latched at start.
- iwbase, in, pADDR_W, first write address; latched at start.
- iwsel, in, 1, target bank; latched at start.
- ilen, in, pADDR_W+1, number of words to process (0..2**pADDR_W).
- ibeta, in, pNUM/2, partial-sum bits u for g. Must be valid for the word issued at cycle t at cycle t+1+pPIPE, i.e. the same timing as ordat.
- oraddr, out, pADDR_W, RAM read address.
- ordat_in, in, pNUM x pDAT_W, RAM ordat.
- owrite, out, 1, RAM write strobe.
- owaddr, out, pADDR_W, RAM write address.
- owsel, out, 1, RAM write bank.
- owdat, out, pNUM/2 x pDAT_W, RAM write data.
- obusy, out, 1, high from the start cycle until done.
- odone, out, 1, one-cycle pulse after the last write.

Behaviour:
- Reset values: owrite=0, odone=0, obusy=0, oraddr=0, owaddr=0, owsel=0, owdat all 0; FSM returns to IDLE.
- Reset mid-pass aborts the pass immediately. No further writes are issued.
- FSM states and transitions:
  - IDLE: on istart with ilen>0, latch the inputs and go to READ. On istart with ilen=0, go straight to DONE with no writes.
  - READ: oraddr = irbase+k for k = 0..len-1, one word per enabled cycle. After the last issue, go to DRAIN.
  - DRAIN: wait until the in-flight count reaches 0, then go to DONE.
  - DONE: odone=1 for one enabled cycle, then go to IDLE.
- Address arithmetic wraps modulo 2**pADDR_W on both read and write addresses.
- Latency: word k is issued at cycle t; data arrives at t+1+pPIPE; owrite for word k is registered at t+2+pPIPE.
- Write address: owaddr = iwbase+k. owsel = latched iwsel.
- Throughput: one word per cycle. Writes appear in issue order with no gaps while iclkena stays high.
- Valid tracking: a shift register of depth 1+pPIPE, aligned with the RAM pipe, marks which returning data is valid.
- iclkena low freezes the FSM, the shift register and all outputs. This stays consistent because the RAM shares the same iclkena.
- istart while busy is ignored.
- f function, per lane: f = sign(a) XOR sign(b) applied to min(|a|,|b|). |x| saturates at 2**(pDAT_W-1)-1, so -128 maps to 127 for pDAT_W=8.
- g function, per lane: g = b + a when u=0, g = b - a when u=1.
  - Computed at pDAT_W+1 bits.
  - Saturated symmetrically to ±(2**(pDAT_W-1)-1).
- ibeta is ignored in f mode.
- Read-after-write hazard: when the write range overlaps the read range, a read returns the old contents. The RAM has no read/write check.
- obusy drops in the same cycle that odone rises.

Test Plan:
- f mode, pDAT_W=8, pNUM=8, irbase=0, iwbase=16, ilen=1, a={5,-3,-128,0}, b={-2,-7,4,9} -> one write at addr 16 with owdat={-2,3,-4,0}. With pPIPE=0, owrite occurs 2 cycles after the issue; odone follows 1 cycle after.
- g mode, a={100,-100,3,-128}, b={100,-100,-4,0}, u={0,0,1,1} -> owdat={127,-127,-7,127}, exercising saturation.
- Pipeline: ilen=4, irbase=254, iwbase=255, pPIPE=1 -> reads at 254,255,0,1 and writes at 255,0,1,2 on 4 consecutive cycles. Writes start 3 cycles after the first issue; exactly 4 owrite pulses.
- Start with ilen=0 -> odone pulses the next cycle; no owrite. istart pulsed during a busy pass -> ignored, write count unchanged.
- Hold iclkena low for 3 cycles mid-pass -> outputs frozen; same write sequence as without the stall, shifted by 3 cycles.
- Assert ireset during READ with ilen=8 -> the next cycle has owrite=0 and obusy=0; a new start after reset runs cleanly.

Source files
------------

// File: rtl/pc_3gpp_alpha_engine.sv
// pc_3gpp_alpha_engine: polar SC node stage, streams alpha words through lane-wise min-sum f/g.
module pc_3gpp_alpha_engine #(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8,
  parameter int pNUM    = 8,
  parameter int pPIPE   = 0
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        iclkena,
  input  logic                        istart,
  input  logic                        imode,
  input  logic [pADDR_W-1:0]          irbase,
  input  logic [pADDR_W-1:0]          iwbase,
  input  logic                        iwsel,
  input  logic [pADDR_W:0]            ilen,
  input  logic [pNUM/2-1:0]           ibeta,
  output logic [pADDR_W-1:0]          oraddr,
  input  logic [pNUM*pDAT_W-1:0]      ordat_in,
  output logic                        owrite,
  output logic [pADDR_W-1:0]          owaddr,
  output logic                        owsel,
  output logic [pNUM/2*pDAT_W-1:0]    owdat,
  output logic                        obusy,
  output logic                        odone
);
  localparam int W = pDAT_W;
  localparam int L = pNUM / 2;
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   SMAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   SMIN = -SMAX;
  localparam logic [pADDR_W-1:0]  AONE = 1;
  localparam logic [pADDR_W:0]    CONE = 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [pPIPE:0]         vld_q;
  logic [pPIPE+1:0]       vld_sh;
  logic [pADDR_W-1:0]     oraddr_q, waddr_q, owaddr_q;
  logic [pADDR_W:0]       cnt_q;
  logic                   mode_q, owsel_q, owrite_q, issue;
  logic [L*W-1:0]         owdat_q, res;
  assign issue  = state_q == READ;
  assign vld_sh = {vld_q, issue};
  assign oraddr = oraddr_q;
  assign owaddr = owaddr_q;
  assign owsel  = owsel_q;
  assign owrite = owrite_q;
  assign owdat  = owdat_q;
  assign obusy  = state_q == READ || state_q == DRAIN;
  assign odone  = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = istart ? (ilen != '0 ? READ : DONE) : IDLE;
      READ:    state_d = cnt_q == CONE ? DRAIN : READ;
      DRAIN:   state_d = vld_q == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      oraddr_q <= '0;
      waddr_q  <= '0;
      owaddr_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      owsel_q  <= 1'b0;
      owrite_q <= 1'b0;
      owdat_q  <= '0;
    end else if (iclkena) begin
      state_q  <= state_d;
      vld_q    <= vld_sh[pPIPE:0];
      owrite_q <= vld_q[pPIPE];
      if (state_q == IDLE && istart) begin
        mode_q   <= imode;
        oraddr_q <= irbase;
        waddr_q  <= iwbase;
        owsel_q  <= iwsel;
        cnt_q    <= ilen;
      end
      if (issue) begin
        oraddr_q <= oraddr_q + AONE;
        cnt_q    <= cnt_q - CONE;
      end
      if (vld_q[pPIPE]) begin
        owdat_q  <= res;
        owaddr_q <= waddr_q;
        waddr_q  <= waddr_q + AONE;
      end
    end
  end
  genvar i;
  for (i = 0; i < L; i++) begin : g_lane
    logic signed [W-1:0] a, b, aa, ab, m, fv, gv;
    logic signed [W:0]   s;
    assign a  = ordat_in[i*W +: W];
    assign b  = ordat_in[(i+L)*W +: W];
    assign aa = (a == MINV) ? MAXV : (a[W-1] ? -a : a);
    assign ab = (b == MINV) ? MAXV : (b[W-1] ? -b : b);
    assign m  = (aa < ab) ? aa : ab;
    assign fv = (a[W-1] ^ b[W-1]) ? -m : m;
    // one extra bit holds b +/- a exactly before symmetric clamp
    assign s  = {b[W-1], b} + (ibeta[i] ? -{a[W-1], a} : {a[W-1], a});
    assign gv = (s > SMAX) ? MAXV : (s < SMIN) ? -MAXV : s[W-1:0];
    assign res[i*W +: W] = mode_q ? gv : fv;
  end
endmodule

// File: tb/tb_pc_3gpp_alpha_engine.sv
// tb_pc_3gpp_alpha_engine: scoreboard bench with a behavioural alpha RAM (pPIPE=1).
module tb_pc_3gpp_alpha_engine;
  localparam int P = 1;
  typedef struct {logic [7:0] addr; logic sel; logic [31:0] dat;} exp_t;
  logic clk = 0, ireset, iclkena, istart, imode, iwsel;
  logic [7:0] irbase, iwbase, oraddr, owaddr;
  logic [8:0] ilen;
  logic [3:0] ibeta;
  logic [63:0] ordat;
  logic owrite, owsel, obusy, odone;
  logic [31:0] owdat;
  logic [63:0] mem [256];
  logic [3:0] bmem [256];
  logic [63:0] r1, r2;
  logic [3:0] u1, u2;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;
  int wr_cnt = 0, wr_first = 0, wr_last = 0, done_cnt = 0, done_cyc = 0, done_base = 0, st_cyc = 0;
  always #5 clk = ~clk;
  pc_3gpp_alpha_engine #(.pADDR_W(8), .pDAT_W(8), .pNUM(8), .pPIPE(P)) dut (
    .iclk(clk), .ireset(ireset), .iclkena(iclkena), .istart(istart), .imode(imode),
    .irbase(irbase), .iwbase(iwbase), .iwsel(iwsel), .ilen(ilen), .ibeta(ibeta),
    .oraddr(oraddr), .ordat_in(ordat), .owrite(owrite), .owaddr(owaddr), .owsel(owsel),
    .owdat(owdat), .obusy(obusy), .odone(odone));
  always @(posedge clk) begin
    cyc++;
    if (iclkena) begin
      r1 <= mem[oraddr];
      r2 <= r1;
      u1 <= bmem[oraddr];
      u2 <= u1;
    end
  end
  assign ordat = P ? r2 : r1;
  assign ibeta = P ? u2 : u1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] p4(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction
  function automatic logic [31:0] model(input logic [63:0] w, input logic [3:0] u, input logic md);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      int a, b, ma, mb, r;
      a = int'(signed'(w[i*8 +: 8]));
      b = int'(signed'(w[(i+4)*8 +: 8]));
      if (!md) begin
        ma = a < 0 ? -a : a;
        mb = b < 0 ? -b : b;
        if (ma > 127) ma = 127;
        if (mb > 127) mb = 127;
        r = ma < mb ? ma : mb;
        if ((a < 0) != (b < 0)) r = -r;
      end else begin
        r = u[i] ? b - a : b + a;
        if (r > 127) r = 127;
        if (r < -127) r = -127;
      end
      o[i*8 +: 8] = r[7:0];
    end
    return o;
  endfunction
  always @(negedge clk) begin
    if (iclkena && !ireset) begin
      if (owrite) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("waddr", owaddr, e.addr);
          check("wsel", owsel, e.sel);
          check("wdat", owdat, e.dat);
        end
        wr_cnt++;
        if (wr_cnt == 1) wr_first = cyc;
        wr_last = cyc;
      end
      if (odone) begin
        check("busy_at_done", obusy, 0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run(input logic md, input logic [7:0] rb, input logic [7:0] wb, input logic sel,
                     input logic [8:0] len, input bit push);
    if (push)
      for (int k = 0; k < int'(len); k++) begin
        logic [7:0] ra;
        ra = rb + 8'(k);
        sb.push_back('{wb + 8'(k), sel, model(mem[ra], bmem[ra], md)});
      end
    imode = md; irbase = rb; iwbase = wb; iwsel = sel; ilen = len; istart = 1;
    wr_cnt = 0;
    done_base = done_cnt;
    @(negedge clk);
    st_cyc = cyc + 1;
    tick(1);
    istart = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done_cnt == done_base && n < 300) begin
      tick(1);
      n++;
    end
    if (done_cnt == done_base) check("timeout", 0, 1);
    tick(1);
  endtask
  initial begin
    ireset = 1; iclkena = 1; istart = 0; imode = 0; iwsel = 0;
    irbase = 0; iwbase = 0; ilen = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom};
      bmem[i] = 4'($urandom_range(0, 15));
    end
    mem[0] = {p4(-2, -7, 4, 9), p4(5, -3, -128, 0)};
    mem[1] = {p4(100, -100, -4, 0), p4(100, -100, 3, -128)};
    bmem[1] = 4'b1100;
    tick(3);
    check("rst_owrite", owrite, 0);
    check("rst_odone", odone, 0);
    check("rst_obusy", obusy, 0);
    check("rst_oraddr", oraddr, 0);
    check("rst_owaddr", owaddr, 0);
    check("rst_owsel", owsel, 0);
    check("rst_owdat", owdat, 0);
    ireset = 0;
    tick(2);
    sb.push_back('{8'd16, 1'b1, p4(-2, 3, -4, 0)});
    run(0, 0, 16, 1, 1, 0);
    wait_done();
    check("f_wcnt", wr_cnt, 1);
    check("f_lat", wr_first - st_cyc, 2 + P);
    check("f_done", done_cyc - wr_last, 1);
    sb.push_back('{8'd20, 1'b0, p4(127, -127, -7, 127)});
    run(1, 1, 20, 0, 1, 0);
    wait_done();
    check("g_wcnt", wr_cnt, 1);
    run(1, 254, 255, 1, 4, 1);
    wait_done();
    check("p_wcnt", wr_cnt, 4);
    check("p_lat", wr_first - st_cyc, 2 + P);
    check("p_span", wr_last - wr_first, 3);
    check("p_done", done_cyc - wr_last, 1);
    run(0, 5, 5, 0, 0, 1);
    wait_done();
    check("z_wcnt", wr_cnt, 0);
    check("z_done", done_cyc - st_cyc, 0);
    run(0, 10, 40, 0, 6, 1);
    tick(2);
    istart = 1; ilen = 3; irbase = 99; iwbase = 7; imode = 1;
    tick(1);
    istart = 0;
    wait_done();
    check("busy_wcnt", wr_cnt, 6);
    run(1, 30, 60, 1, 5, 1);
    tick(2);
    iclkena = 0;
    tick(3);
    iclkena = 1;
    wait_done();
    check("s_wcnt", wr_cnt, 5);
    check("s_done", done_cyc - st_cyc, 5 + 2 + P + 3);
    run(0, 100, 200, 0, 8, 1);
    tick(2);
    ireset = 1;
    tick(1);
    ireset = 0;
    sb.delete();
    check("r_owrite", owrite, 0);
    check("r_obusy", obusy, 0);
    tick(4);
    check("r_quiet", wr_cnt < 8, 1);
    run(1, 100, 210, 1, 3, 1);
    wait_done();
    check("r2_wcnt", wr_cnt, 3);
    check("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
